// File: rtl/ysyx_24100029_icache.sv
// Direct-mapped read-only instruction cache: single-beat upstream fetches,
// whole-line INCR burst refills downstream, fence_i invalidates every line.
module ysyx_24100029_icache #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 16,
    parameter int unsigned ID         = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fence_i,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [3:0]        m_arid,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
);

    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = ADDR_W - OW - IW - 2;
    localparam int unsigned CW = OW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic              fence_pend_q, fence_pend_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [TW-1:0]     tag_q  [SETS];
    logic [31:0]       data_q [SETS*LINE_WORDS];

    logic              data_we;
    logic              tag_we;
    logic [OW-1:0]     req_off;
    logic [IW-1:0]     req_idx;
    logic [TW-1:0]     req_tag;
    logic              hit;
    logic              fence_now;
    logic              unused_addr_lsb;

    assign req_off         = addr_q[OW+1:2];
    assign req_idx         = addr_q[OW+IW+1:OW+2];
    assign req_tag         = addr_q[ADDR_W-1:OW+IW+2];
    assign hit             = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fence_now       = fence_i || fence_pend_q;
    assign unused_addr_lsb = ^addr_q[1:0];

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        fence_pend_d = fence_pend_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        if (fence_i && (state_q != S_IDLE)) begin
            fence_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (fence_now) begin
                    valid_d      = '0;
                    fence_pend_d = 1'b0;
                end else if (s_arvalid) begin
                    addr_d  = s_araddr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    rdata_d = data_q[{req_idx, req_off}];
                    rresp_d = 2'b00;
                    state_d = S_RESP;
                end else begin
                    state_d = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                if (m_arready) begin
                    // The refill overwrites the set, so the old line is dropped now
                    valid_d[req_idx] = 1'b0;
                    cnt_d            = '0;
                    err_d            = 1'b0;
                    state_d          = S_MISS_R;
                end
            end
            S_MISS_R: begin
                if (m_rvalid) begin
                    if (cnt_q < CW'(LINE_WORDS)) begin
                        data_we = 1'b1;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q[OW-1:0] == req_off) begin
                            rdata_d = m_rdata;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (m_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (m_rlast) begin
                        if (!err_d && (cnt_q == CW'(LINE_WORDS - 1))) begin
                            tag_we           = 1'b1;
                            valid_d[req_idx] = 1'b1;
                            rresp_d          = 2'b00;
                        end else begin
                            rresp_d = 2'b10;
                            rdata_d = 32'h0;
                        end
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (s_rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            rresp_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            fence_pend_q <= fence_pend_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every read
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_q[{req_idx, cnt_q[OW-1:0]}] <= m_rdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    assign s_arready = reset && (state_q == S_IDLE) && !fence_now;
    assign s_rvalid  = (state_q == S_RESP);
    assign s_rlast   = (state_q == S_RESP);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign m_arvalid = (state_q == S_MISS_AR);
    assign m_araddr  = {req_tag, req_idx, {(OW + 2){1'b0}}};
    assign m_arid    = 4'(ID);
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_rready  = (state_q == S_MISS_R);

endmodule

// File: doc/ysyx_24100029_icache.md
Name: ysyx_24100029_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU AXI4 read master and the system crossbar.
- IFU issues single-beat 32-bit fetches on the upstream port (s_*).
- Hits return from local storage. Misses refill one full line with an AXI4 INCR burst on the downstream port (m_*).
- Write channels are not handled here; IFU ties them off.

Parameters:
ADDR_W, 32, address width
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
SETS, 16, number of lines (power of 2)
ID, 0, AXI ID driven on m_arid

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
fence_i  in  1  one-cycle pulse: invalidate all lines
s_arvalid  in  1  fetch request valid
s_arready  out  1  fetch request accepted
s_araddr  in  ADDR_W  fetch address (word aligned)
s_rvalid  out  1  fetch data valid
s_rready  in  1  upstream accepts data
s_rdata  out  32  instruction word
s_rresp  out  2  00 OKAY, 10 SLVERR on refill error
s_rlast  out  1  always 1 when s_rvalid
m_arvalid  out  1  refill request
m_arready  in  1  downstream accepts address
m_araddr  out  ADDR_W  line-aligned refill address
m_arid  out  4  = ID
m_arlen  out  8  = LINE_WORDS-1
m_arsize  out  3  = 3'b010
m_arburst  out  2  = 2'b01 (INCR)
m_rvalid  in  1  refill beat valid
m_rready  out  1  refill beat accepted
m_rdata  in  32  refill beat data
m_rresp  in  2  refill beat response
m_rlast  in  1  last refill beat

Behaviour:
Address split:
- offset = addr[log2(LINE_WORDS)+1:2]
- index = next log2(SETS) bits
- tag = remaining upper bits
- addr[1:0] is ignored.

Storage:
- Per set: valid bit, tag, LINE_WORDS data words.
- Only the valid bits are reset. Tag and data arrays are not.

Reset (reset=0, asynchronous):
- FSM goes to IDLE.
- All valid bits cleared; fence_pend=0; beat counter=0.
- Output values during reset: s_arready=0, s_rvalid=0, s_rdata=0, s_rresp=0, s_rlast=0, m_arvalid=0, m_rready=0.
- Any in-flight refill is abandoned. The downstream slave must also be reset.

FSM:
- IDLE:
  - s_arready=1, unless fence_i or fence_pend is being serviced this cycle.
  - On s_arvalid&s_arready, latch the address and go to LOOKUP.
- LOOKUP:
  - Hit (valid&&tag match): load s_rdata from the array, s_rresp=00, go to RESP.
  - Miss: go to MISS_AR.
- MISS_AR:
  - m_arvalid=1 with m_araddr = {tag,index,0}.
  - Hold all m_ar* stable until m_arready, then go to MISS_R with beat counter=0.
- MISS_R:
  - m_rready=1. Each m_rvalid beat writes word[counter] and increments the counter.
  - Any m_rresp!=00 sets a sticky err flag.
  - On the beat with m_rlast=1:
    - If err==0 and counter==LINE_WORDS-1: set valid[index], write the tag, s_rdata = requested word (forwarded from m_rdata if it is the last beat), s_rresp=00.
    - Otherwise: line stays invalid, s_rresp=10, s_rdata=0.
  - Then go to RESP.
- RESP:
  - s_rvalid=1, s_rlast=1; hold s_rdata/s_rresp stable until s_rready.
  - On s_rvalid&s_rready: s_rvalid=0, go to IDLE.

Latency:
- Hit: 2 cycles, request handshake to s_rvalid.
- Miss: 3 + AR wait + LINE_WORDS beats + beat gaps.

Ordering and boundary rules:
- One outstanding request at a time; s_arready=0 in every state except IDLE.
- Beats arriving after counter reaches LINE_WORDS-1 without m_rlast: ignore the write, set err, continue until m_rlast.
- fence_i in IDLE: all valid bits cleared at the next edge; s_arready=0 that cycle.
- fence_i in any other state: sets fence_pend. The current transaction completes normally, including installing its line. Valid bits clear in the first IDLE cycle, then fence_pend=0.
- A request arriving in the same IDLE cycle as a fence waits; s_arready=0.
- Index wrap: the top set maps to addresses whose index bits are all 1. Incrementing past it wraps via the tag bits; no special case is needed.

Test Plan:
- Cold fetch 0x30000000, slave returns 0x11,0x22,0x33,0x44 OKAY -> m_araddr=0x30000000, m_arlen=3, m_arburst=01; s_rdata=0x11, s_rresp=00.
- Then fetch 0x3000000C -> no m_arvalid; s_rvalid exactly 2 cycles after handshake with s_rdata=0x44.
- Fetch 0x30000100 (same index as 0x30000000 when SETS=16, LINE_WORDS=4) -> refill issued; a following fetch of 0x30000000 misses again.
- Refill with m_rresp=10 on beat 2 -> s_rresp=10, s_rdata=0; a repeat fetch of the same address re-issues m_arvalid.
- fence_i pulsed during MISS_R -> current fetch returns correct data; the next fetch of the same line misses.
- Hold s_rready=0 for 5 cycles in RESP; assert reset=0 mid-refill -> s_rdata stable until accept; after reset release every fetch misses and s_arready=1 in IDLE.
